// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants for the digit-serial BCD adder: FSM encoding and BCD digit limits.
package bcd_serial_adder_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_adder_ctrl_digit_adder.sv
// One BCD digit plus decimal carry-in; combinational, shared by the serial controller.
module bcd_digit_adder
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               c,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry,
    output logic               dig_err
);

    logic [DIGIT_W:0] w_s;

    assign w_s = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, c};

    always_comb begin
        if (w_s > {1'b0, BCD_MAX}) begin
            // +6 skips the six unused binary codes; truncation drops the decimal carry
            digit = w_s[DIGIT_W-1:0] + BCD_CORR;
            carry = 1'b1;
        end else begin
            digit = w_s[DIGIT_W-1:0];
            carry = 1'b0;
        end
        dig_err = (a_d > BCD_MAX) | (b_d > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Adds two packed-BCD operands one digit per clock through a single shared digit adder.
//   state   | meaning
//   ST_IDLE | waiting for start; results from the last request held
//   ST_ADD  | processing digit r_idx, rippling the decimal carry
//   ST_DONE | one-cycle result-valid pulse
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err
);

    localparam int W = DIGIT_W * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic [IDX_W-1:0]   r_idx;

    logic [DIGIT_W-1:0] w_a_d;
    logic [DIGIT_W-1:0] w_b_d;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_carry;
    logic               w_dig_err;
    logic               w_last;

    assign w_last = (r_idx == LAST_IDX);

    always_comb begin
        w_a_d = '0;
        w_b_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_d = r_a[i*DIGIT_W +: DIGIT_W];
                w_b_d = r_b[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    bcd_digit_adder u_digit (
        .a_d     (w_a_d),
        .b_d     (w_b_d),
        .c       (r_carry),
        .digit   (w_digit),
        .carry   (w_carry),
        .dig_err (w_dig_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start)  w_next = ST_ADD;
            ST_ADD:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                        r_sum   <= '0;
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDX_W'(i)) r_sum[i*DIGIT_W +: DIGIT_W] <= w_digit;
                    end
                    r_carry <= w_carry;
                    r_err   <= r_err | w_dig_err;
                    if (w_last) begin
                        r_cout <= w_carry;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench: expected {err,cout,sum} queued at issue, compared by a monitor on each done pulse.
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] sb_q[$];

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS), .IDX_W(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Valid operands: decimal integer addition. Invalid digits: the per-digit rule, as the result is then only defined digit-wise.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        int va, vb, pw, tot, da, db, c, t;
        logic e, co;
        logic [W-1:0] s;
        va = 0; vb = 0; pw = 1; e = 1'b0; s = '0; co = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            da = int'(ma[4*i +: 4]);
            db = int'(mb[4*i +: 4]);
            if (da > 9 || db > 9) e = 1'b1;
            va = va * 10 + da;
            vb = vb * 10 + db;
            pw = pw * 10;
        end
        if (!e) begin
            tot = va + vb + int'(mc);
            co  = (tot >= pw);
            tot = tot % pw;
            for (int i = 0; i < DIGITS; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = int'(mc);
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + c;
                if (t > 9) begin
                    s[4*i +: 4] = 4'(t + 6);
                    c = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            co = (c != 0);
        end
        return {e, co, s};
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 3) == 0))
            v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                chk("result", 32'({err, cout, sum}), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic run_req(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        logic [W+1:0] exp;
        int k;
        bit got;
        exp = model(ia, ib, ic);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        got = 1'b0;
        while (k <= 3 * DIGITS + 10 && !got) begin
            if (k <= DIGITS) begin
                chk("busy_in_add", 32'({busy, done}), 32'b10);
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
            end
            if (done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("done_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(DIGITS + 1));
        chk("busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("idle_busy", 32'({busy, done}), 32'b00);
        chk("result_held", 32'({err, cout, sum}), 32'(exp));
    endtask

    initial begin
        logic [W+1:0] e3;
        int npulse;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("reset_ctrl", 32'({busy, done, cout, err}), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_req(16'h1999, 16'h0001, 1'b0);
        run_req(16'h9999, 16'h0001, 1'b0);
        run_req(16'h0009, 16'h0007, 1'b1);
        run_req(16'h00A0, 16'h0003, 1'b0);
        repeat (2) @(negedge clk);
        chk("err_held_idle", 32'(err), 32'd1);
        run_req(16'h0001, 16'h0001, 1'b0);
        run_req(16'h0000, 16'h0000, 1'b1);
        run_req(16'h5000, 16'h5000, 1'b0);
        run_req(16'h9999, 16'h9999, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_req(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom));
        end

        // start held high: back-to-back requests every DIGITS+2 cycles
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        e3 = model(16'h1234, 16'h4321, 1'b0);
        repeat (3) sb_q.push_back(e3);
        npulse = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (done) npulse++;
            if (k == 5 || k == 11 || k == 17) chk("cont_done", 32'(done), 32'd1);
            if (k == 6) chk("cont_gap_busy", 32'(busy), 32'd0);
            if (k == 17) start = 1'b0;
        end
        chk("cont_pulses", 32'(npulse), 32'd3);
        chk("cont_no_restart", 32'(busy), 32'd0);

        // reset in cycle 3 of a request
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midreset_ctrl", 32'({busy, done, cout, err}), 32'd0);
        chk("midreset_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("no_done_after_reset", 32'(npulse), 32'd0);
        run_req(16'h0001, 16'h0001, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Sequencer that adds two multi-digit packed-BCD operands by reusing one single-digit BCD adder, least-significant digit first, one digit per clock. It sits between a requester (start/done handshake) and the shared digit datapath. It latches the operands, steps a digit index, ripples the decimal carry through a register, and reports carry-out and an invalid-digit error. Intended as the sequential front end for the team's BCD arithmetic blocks.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1)
IDX_W, 2, width of digit index; must satisfy 2**IDX_W >= DIGITS

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  decimal carry-in
busy  output  1  high while a request is in progress (ADD or DONE)
done  output  1  one-cycle pulse: result valid
sum  output  4*DIGITS  packed BCD result
cout  output  1  decimal carry-out of the top digit
err  output  1  some digit of a or b was >9 (latched operands)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, idx=0, carry register=0, operand registers=0.
- FSM states:
  - IDLE -> ADD when start=1. On that edge: latch a, b; carry<=cin; idx<=0; err<=0; sum<=0.
  - ADD: each cycle processes digit idx. Writes sum digit idx and carry. ORs the digit error into err. Increments idx.
  - ADD -> DONE after the edge that processes digit DIGITS-1. That edge writes cout<=digit carry. idx wraps to 0.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- Latency:
  - start edge = cycle 0. ADD occupies cycles 1..DIGITS. done=1 in cycle DIGITS+1.
  - Next start is accepted in cycle DIGITS+2 at the earliest.
- busy: high in ADD and DONE, low in IDLE.
- Results: sum, cout and err hold their values after DONE until the next accepted start. The accepting start clears sum and err.
- start outside IDLE is ignored; there is no queueing. Changes to a and b after the start edge have no effect.
- Digit arithmetic (sub-module):
  - s = a_d + b_d + c, 5 bits.
  - If s>9: digit=(s+6)[3:0], carry=1. Otherwise digit=s[3:0], carry=0.
  - dig_err = (a_d>9) | (b_d>9).
- Invalid digits:
  - err is sticky for the whole request.
  - Computation continues with the same rule, so the sum is defined but meaningless.
  - done still pulses at the normal time.
- Reset mid-operation: asynchronous return to reset values; the partial result is discarded and no done pulse is produced.
- Required state count: DIGITS=1 must work (exactly one ADD cycle).

Decomposition:
- Shared package: FSM state encoding constants (ST_IDLE, ST_ADD, ST_DONE), BCD_MAX=9, BCD_CORR=6, DIGIT_W=4.
- One combinational sub-module, bcd_digit_adder:
  - Inputs: a_d, b_d, c.
  - Outputs: digit, carry, dig_err.
  - Built on the team's existing binary adder cells.
- The controller instantiates exactly one bcd_digit_adder and muxes its inputs with idx.

Test Plan (all with DIGITS=4):
- a=0x1999, b=0x0001, cin=0, start pulse -> done in cycle 5; sum=0x2000, cout=0, err=0; busy high in cycles 1-5.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0. Then a=0x0009, b=0x0007, cin=1 -> sum=0x0017, cout=0.
- a=0x00A0, b=0x0003 -> err=1 at done and held in IDLE; the next clean request (a=0x0001, b=0x0001) gives err=0, sum=0x0002.
- Hold start=1 continuously with a=0x1234, b=0x4321 -> done in cycles 5, 11, 17; sum=0x5555 each time. Change a during ADD -> result unaffected.
- Assert rst for 1 cycle during cycle 3 of a request -> all outputs 0 immediately, no done pulse. The next request completes normally.
- Boundary: a=0x0000, b=0x0000, cin=1 -> sum=0x0001. a=0x5000, b=0x5000 -> sum=0x0000, cout=1.
